// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: ALU function codes,
// sequencer state encoding and a function-code classifier.
package shift_sequencer_pkg;

    // ALU function codes shared with the rest of the datapath
    typedef enum logic [3:0] {
        FUNC_ADD = 4'h0,
        FUNC_SUB = 4'h1,
        FUNC_AND = 4'h2,
        FUNC_OR  = 4'h3,
        FUNC_XOR = 4'h4,
        FUNC_LLS = 4'h5,
        FUNC_LRS = 4'h6,
        FUNC_ALS = 4'h7,
        FUNC_ARS = 4'h8
    } alu_func_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // True for the four codes the sequencer knows how to execute
    function automatic logic is_shift_func(input logic [3:0] f);
        return f inside {FUNC_LLS, FUNC_LRS, FUNC_ALS, FUNC_ARS};
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between a shift-sequencer client (master)
// and the sequencer (slave). abort exists only with SHIFT_SEQ_ABORT_EN.
interface shift_sequencer_if #(
    parameter int data_width = 16,
    parameter int amt_width  = 4
);
    logic                  start;
    logic [3:0]            func_code;
    logic [data_width-1:0] a;
    logic [amt_width-1:0]  amount;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [data_width-1:0] result;
`ifdef SHIFT_SEQ_ABORT_EN
    logic                  abort;
`endif

    modport master (
`ifdef SHIFT_SEQ_ABORT_EN
        output abort,
`endif
        output start, func_code, a, amount,
        input  busy, done, err, result
    );

    modport slave (
`ifdef SHIFT_SEQ_ABORT_EN
        input  abort,
`endif
        input  start, func_code, a, amount,
        output busy, done, err, result
    );
endinterface

// File: rtl/shift_sequencer_shift.sv
// SHIFT unit: one single-bit shift of the selected kind, purely
// combinational. Unknown codes pass the operand through.
module shift_sequencer_shift
    import shift_sequencer_pkg::*;
#(
    parameter int data_width = 16
) (
    input  logic [data_width-1:0] din_i,
    input  logic [3:0]            func_i,
    output logic [data_width-1:0] dout_o
);

    // One-bit shift; ARS replicates the sign bit into the vacated MSB
    always_comb begin
        dout_o = din_i;
        case (func_i)
            FUNC_LLS, FUNC_ALS: dout_o = {din_i[data_width-2:0], 1'b0};
            FUNC_LRS:           dout_o = {1'b0, din_i[data_width-1:1]};
            FUNC_ARS:           dout_o = {din_i[data_width-1], din_i[data_width-1:1]};
            default:            dout_o = din_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: applies one 1-bit shift per cycle
// through the SHIFT unit until the captured count is exhausted.
// Optional feature: define SHIFT_SEQ_ABORT_EN to add an abort input
// that cancels an operation in RUN without a done pulse.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int data_width = 16,
    parameter int amt_width  = 4
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);

    state_e                state_q;
    logic [data_width-1:0] work_q;
    logic [data_width-1:0] shifted;
    logic [amt_width-1:0]  cnt_q;
    logic [3:0]            func_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [data_width-1:0] result_q;

    shift_sequencer_shift #(.data_width(data_width)) u_shift (
        .din_i  (work_q),
        .func_i (func_q),
        .dout_o (shifted)
    );

    // Control FSM plus working register; all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            func_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        work_q <= bus.a;
                        cnt_q  <= bus.amount;
                        func_q <= bus.func_code;
                        // zero count or bad code skip straight to FIN
                        if (bus.amount != '0 && is_shift_func(bus.func_code)) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_RUN: begin
`ifdef SHIFT_SEQ_ABORT_EN
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else
`endif
                    begin
                        work_q <= shifted;
                        cnt_q  <= cnt_q - amt_width'(1);
                        if (cnt_q == amt_width'(1)) begin
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_FIN: begin
                    done_q   <= 1'b1;
                    err_q    <= ~is_shift_func(func_q);
                    result_q <= work_q;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter data_width, default 16, SHALL set operand/result width.
REQ-002 Parameter amt_width, default 4, SHALL set shift-count width (max count 2^amt_width-1).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request an operation; sampled only when busy is low.
REQ-006 func_code  input  4  SHALL select the operation: FUNC_LLS, FUNC_LRS, FUNC_ALS or FUNC_ARS.
REQ-007 a  input  data_width  SHALL be the operand, captured on accept.
REQ-008 amount  input  amt_width  SHALL be the shift count, captured on accept.
REQ-009 busy  output  1  SHALL be high while an accepted operation is in progress.
REQ-010 done  output  1  SHALL pulse high for exactly one cycle when the result is valid.
REQ-011 err  output  1  SHALL be high with done when the captured func_code was not a shift code.
REQ-012 result  output  data_width  SHALL carry the shifted operand, held stable until the next accept.

Function
REQ-013 States SHALL be IDLE, RUN, FIN; reset state IDLE.
REQ-014 IDLE: start high SHALL capture a, amount, func_code; next state RUN if amount>0 and code valid, else FIN.
REQ-015 RUN: each cycle SHALL apply exactly one 1-bit shift of the selected kind to the working register and decrement the remaining count.
REQ-016 RUN SHALL transition to FIN on the cycle the remaining count reaches 0.
REQ-017 FIN: done=1, result=working register, next state IDLE; busy low in FIN.
REQ-018 Latency: done SHALL assert amount+1 cycles after the accepting edge (amount 0 -> 1 cycle).
REQ-019 busy SHALL be high in RUN only; start while busy SHALL be ignored, no queueing.
REQ-020 start in FIN SHALL be ignored; earliest re-accept is the cycle after done (back-to-back throughput amount+2 cycles).
REQ-021 LLS/ALS SHALL shift left filling 0; LRS SHALL shift right filling 0; ARS SHALL shift right replicating bit data_width-1 each step.
REQ-022 Invalid func_code SHALL produce done and err with result = captured a, no shift.
REQ-023 Changes on a, amount, func_code after accept SHALL NOT affect the operation in progress.

Reset
REQ-024 Reset SHALL force state IDLE, busy=0, done=0, err=0, result=0, count=0, immediately and independent of clk.
REQ-025 Reset asserted mid-RUN SHALL abandon the operation with no done pulse after release.
REQ-026 First accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro SHIFT_SEQ_ABORT_EN SHALL, when defined, add input abort (1 bit).
REQ-028 With SHIFT_SEQ_ABORT_EN: abort high in RUN SHALL return to IDLE next edge, no done, result unchanged from prior value; abort in IDLE/FIN has no effect; abort and start together in IDLE -> start wins.
REQ-029 Without SHIFT_SEQ_ABORT_EN: no abort port; every accepted operation SHALL complete.

Structure
REQ-030 FUNC_LLS/LRS/ALS/ARS codes SHALL come from the shared alu_func definitions; no local redefinition.
REQ-031 State encodings SHALL live in a shared header shift_seq_defs, included by RTL and bench.
REQ-032 The per-cycle 1-bit shift SHALL be one instance of the existing SHIFT unit (data_width passed through); the sequencer holds only control and working register.

Verification
REQ-033 LLS a=0x0001 amount=4 -> done 5 cycles after accept, result=0x0010, err=0.
REQ-034 ARS a=0x8000 amount=3 -> result=0xF000; LRS a=0x8000 amount=15 -> result=0x0001 after 16 cycles.
REQ-035 amount=0, ALS a=0x1234 -> done next cycle, result=0x1234; invalid func_code -> done+err, result=a.
REQ-036 start pulsed during RUN with different a -> ignored; first result unchanged; re-accept the cycle after done succeeds.
REQ-037 reset asserted mid-RUN (LLS, amount=10, after 3 shifts) -> outputs 0 immediately, no done after release.
REQ-038 With SHIFT_SEQ_ABORT_EN: abort at 2nd RUN cycle -> IDLE next edge, no done, result keeps previous value.
